// File: rtl/pc_pkg.sv
// Purpose : shared types and constants for the program counter block.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package pc_pkg;

    localparam int PC_W            = 8;
    localparam int DEF_MEM_DEPTH   = 66;
    localparam int DEF_STACK_DEPTH = 4;

    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_e;

    // Winning request in RUN, highest priority last in this list.
    typedef enum logic [2:0] {
        SEL_INC    = 3'd0,
        SEL_BRANCH = 3'd1,
        SEL_JUMP   = 3'd2,
        SEL_CALL   = 3'd3,
        SEL_RET    = 3'd4,
        SEL_HALT   = 3'd5
    } sel_e;

    // True when an address lies inside program memory.
    function automatic logic in_range(input pc_t a, input int depth);
        return ({{(32-PC_W){1'b0}}, a} < 32'(depth));
    endfunction

endpackage

// File: rtl/program_counter_if.sv
// Purpose : request/status bundle between sequencer and program counter.
// Latency : n/a (wires only).
// Backpressure: none; requests are sampled every cycle.
// Ports   : master drives requests and reads PC/status; slave is the PC block.
interface program_counter_if;
    import pc_pkg::*;

    logic halt_req;
    logic resume;
    logic jump;
    pc_t  jump_addr;
    logic branch;
    logic branch_cond;
    pc_t  branch_off;
    logic call;
    logic ret;
    pc_t  PC;
    logic halted;
    logic stack_err;
    logic addr_err;

    modport master (
        output halt_req, resume, jump, jump_addr, branch, branch_cond,
               branch_off, call, ret,
        input  PC, halted, stack_err, addr_err
    );

    modport slave (
        input  halt_req, resume, jump, jump_addr, branch, branch_cond,
               branch_off, call, ret,
        output PC, halted, stack_err, addr_err
    );
endinterface

// File: rtl/program_counter_return_stack.sv
// Purpose : small LIFO of return addresses for call/ret.
// Latency : push/pop take effect on the posedge; top_o is combinational from sp.
// Backpressure: none; push when full / pop when empty are ignored (caller flags them).
// Ports   : clock, reset (async active-low), push_i/pop_i/din_i in; full_o/empty_o/top_o out.
module return_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] top_o
);
    localparam int SPW  = $clog2(DEPTH + 1);
    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SPW-1:0] sp_q, sp_d;
    logic [SPW-1:0] sp_m1;
    logic [W-1:0]   mem_q [DEPTH];

    assign sp_m1   = sp_q - SPW'(1);
    assign full_o  = (sp_q == SPW'(DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_o   = mem_q[sp_m1[IDXW-1:0]];

    always_comb begin
        sp_d = sp_q;
        if (push_i && !full_o) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_i && !empty_o) begin
            sp_d = sp_m1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // Entry contents need no reset: only slots below sp are ever read.
    always_ff @(posedge clock) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[IDXW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/program_counter.sv
// Purpose : fetch-side PC sequencer with jump/branch/call/ret, halt mode and sticky faults.
// Latency : requests sampled at posedge N, new PC visible right after it (memory reads at negedge N).
// Backpressure: none; HALT freezes PC and ignores flow requests until resume.
// Ports   : clock, reset (async active-low), bus (program_counter_if.slave).
module program_counter
    import pc_pkg::*;
#(
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int RESET_ADDR  = 0,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic               clock,
    input  logic               reset,
    program_counter_if.slave   bus
);
    state_e state_q, state_d;
    pc_t    pc_q, pc_d;
    logic   stack_err_q, stack_err_d;
    logic   addr_err_q, addr_err_d;

    sel_e   sel;
    pc_t    cand;
    logic   cand_ok;
    logic   push, pop;
    logic   stk_full, stk_empty;
    pc_t    stk_top;
    pc_t    pc_inc;

    assign pc_inc = pc_q + 8'd1;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (pc_inc),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .top_o   (stk_top)
    );

    // Priority decode and candidate next PC, independent of state.
    always_comb begin
        sel = SEL_INC;
        if (bus.halt_req)                        sel = SEL_HALT;
        else if (bus.ret)                        sel = SEL_RET;
        else if (bus.call)                       sel = SEL_CALL;
        else if (bus.jump)                       sel = SEL_JUMP;
        else if (bus.branch && bus.branch_cond)  sel = SEL_BRANCH;

        case (sel)
            SEL_RET:             cand = stk_top;
            SEL_CALL, SEL_JUMP:  cand = bus.jump_addr;
            SEL_BRANCH:          cand = pc_inc + bus.branch_off;
            default:             cand = pc_inc;
        endcase
        cand_ok = in_range(cand, MEM_DEPTH);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        stack_err_d = stack_err_q;
        addr_err_d  = addr_err_q;
        push        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_RUN: begin
                case (sel)
                    SEL_HALT: state_d = ST_HALT;
                    SEL_RET: begin
                        if (stk_empty) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else if (!cand_ok) begin
                            addr_err_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            pc_d = cand;
                            pop  = 1'b1;
                        end
                    end
                    SEL_CALL: begin
                        // Stack is only touched when the call actually lands.
                        if (stk_full) begin
                            stack_err_d = 1'b1;
                            state_d     = ST_HALT;
                        end else if (!cand_ok) begin
                            addr_err_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            pc_d = cand;
                            push = 1'b1;
                        end
                    end
                    default: begin
                        // Incrementing past the last word faults; no wrap to 0.
                        if (!cand_ok) begin
                            addr_err_d = 1'b1;
                            state_d    = ST_HALT;
                        end else begin
                            pc_d = cand;
                        end
                    end
                endcase
            end
            ST_HALT: begin
                // Leaving HALT does not advance PC on that same edge.
                if (bus.resume && !bus.halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_RUN;
            pc_q        <= PC_W'(RESET_ADDR);
            stack_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            stack_err_q <= stack_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign bus.PC        = pc_q;
    assign bus.halted    = (state_q == ST_HALT);
    assign bus.stack_err = stack_err_q;
    assign bus.addr_err  = addr_err_q;
endmodule

// File: tb/tb_program_counter.sv
// Purpose : directed test of program_counter with a queue-based scoreboard.
// Latency : one expectation per clock edge, checked just after that edge.
// Backpressure: n/a.
module tb_program_counter;
    logic clock;
    logic reset;

    program_counter_if bus();

    program_counter #(
        .MEM_DEPTH   (66),
        .RESET_ADDR  (0),
        .STACK_DEPTH (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] pc;
        logic       h;
        logic       se;
        logic       ae;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string nm, input logic [7:0] pc, input logic h,
                       input logic se, input logic ae);
        n_checks++;
        if (bus.PC !== pc || bus.halted !== h || bus.stack_err !== se || bus.addr_err !== ae) begin
            n_fail++;
            $display("FAIL %s: got PC=%0d halted=%b stack_err=%b addr_err=%b, expected PC=%0d halted=%b stack_err=%b addr_err=%b",
                     nm, bus.PC, bus.halted, bus.stack_err, bus.addr_err, pc, h, se, ae);
        end
    endtask

    // Monitor: one expectation is consumed just after every posedge.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk(e.nm, e.pc, e.h, e.se, e.ae);
        end
    end

    task automatic clr();
        bus.halt_req    = 1'b0;
        bus.resume      = 1'b0;
        bus.jump        = 1'b0;
        bus.jump_addr   = 8'd0;
        bus.branch      = 1'b0;
        bus.branch_cond = 1'b0;
        bus.branch_off  = 8'd0;
        bus.call        = 1'b0;
        bus.ret         = 1'b0;
    endtask

    // Queue the expected post-edge state, let one edge pass, then clear inputs.
    task automatic cyc(input string nm, input logic [7:0] pc, input logic h,
                       input logic se, input logic ae);
        exp_t e;
        e.pc = pc; e.h = h; e.se = se; e.ae = ae; e.nm = nm;
        sb.push_back(e);
        @(posedge clock);
        @(negedge clock);
        clr();
    endtask

    task automatic do_jump(input string nm, input logic [7:0] a, input logic [7:0] pc,
                           input logic h, input logic se, input logic ae);
        bus.jump = 1'b1; bus.jump_addr = a;
        cyc(nm, pc, h, se, ae);
    endtask

    task automatic do_call(input string nm, input logic [7:0] a, input logic [7:0] pc,
                           input logic h, input logic se, input logic ae);
        bus.call = 1'b1; bus.jump_addr = a;
        cyc(nm, pc, h, se, ae);
    endtask

    task automatic do_ret(input string nm, input logic [7:0] pc,
                          input logic h, input logic se, input logic ae);
        bus.ret = 1'b1;
        cyc(nm, pc, h, se, ae);
    endtask

    task automatic do_branch(input string nm, input logic c, input logic [7:0] off,
                             input logic [7:0] pc, input logic h, input logic se, input logic ae);
        bus.branch = 1'b1; bus.branch_cond = c; bus.branch_off = off;
        cyc(nm, pc, h, se, ae);
    endtask

    task automatic do_resume(input string nm, input logic [7:0] pc,
                             input logic se, input logic ae);
        bus.resume = 1'b1;
        cyc(nm, pc, 1'b0, se, ae);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_state", 8'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;

        // Sequential count from reset
        for (int i = 1; i <= 5; i++) cyc($sformatf("inc_%0d", i), 8'(i), 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-count
        reset = 1'b0;
        #1;
        chk("mid_reset", 8'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        // Branches: 10+1-5=6, not taken -> 11, jump beats branch, 30+1+5=36
        do_jump("jump10_a", 8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        do_branch("br_taken_neg", 1'b1, 8'hFB, 8'd6, 1'b0, 1'b0, 1'b0);
        do_jump("jump10_b", 8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        do_branch("br_not_taken", 1'b0, 8'hFB, 8'd11, 1'b0, 1'b0, 1'b0);
        do_jump("jump10_c", 8'd10, 8'd10, 1'b0, 1'b0, 1'b0);
        bus.jump = 1'b1; bus.jump_addr = 8'd30;
        do_branch("jump_over_branch", 1'b1, 8'hFB, 8'd30, 1'b0, 1'b0, 1'b0);
        do_branch("br_taken_pos", 1'b1, 8'h05, 8'd36, 1'b0, 1'b0, 1'b0);

        // Nested call/ret
        do_jump("jump3", 8'd3, 8'd3, 1'b0, 1'b0, 1'b0);
        do_call("call20", 8'd20, 8'd20, 1'b0, 1'b0, 1'b0);
        do_call("call40", 8'd40, 8'd40, 1'b0, 1'b0, 1'b0);
        do_ret("ret_to21", 8'd21, 1'b0, 1'b0, 1'b0);
        do_ret("ret_to4", 8'd4, 1'b0, 1'b0, 1'b0);

        // Pop on empty stack
        do_jump("jump7", 8'd7, 8'd7, 1'b0, 1'b0, 1'b0);
        do_ret("ret_empty", 8'd7, 1'b1, 1'b1, 1'b0);
        do_resume("resume_at7", 8'd7, 1'b1, 1'b0);
        cyc("inc_after_resume", 8'd8, 1'b0, 1'b1, 1'b0);

        // Fill stack (pushes 9,51,52,53), fifth push faults
        do_call("fill_50", 8'd50, 8'd50, 1'b0, 1'b1, 1'b0);
        do_call("fill_51", 8'd51, 8'd51, 1'b0, 1'b1, 1'b0);
        do_call("fill_52", 8'd52, 8'd52, 1'b0, 1'b1, 1'b0);
        do_call("fill_53", 8'd53, 8'd53, 1'b0, 1'b1, 1'b0);
        do_call("push_full", 8'd60, 8'd53, 1'b1, 1'b1, 1'b0);
        do_ret("ret_in_halt", 8'd53, 1'b1, 1'b1, 1'b0);
        do_resume("resume_at53", 8'd53, 1'b1, 1'b0);
        do_ret("pop_53", 8'd53, 1'b0, 1'b1, 1'b0);
        do_ret("pop_52", 8'd52, 1'b0, 1'b1, 1'b0);
        do_ret("pop_51", 8'd51, 1'b0, 1'b1, 1'b0);
        do_ret("pop_9", 8'd9, 1'b0, 1'b1, 1'b0);

        // Address range faults
        do_jump("jump64", 8'd64, 8'd64, 1'b0, 1'b1, 1'b0);
        cyc("inc_to_65", 8'd65, 1'b0, 1'b1, 1'b0);
        cyc("inc_past_end", 8'd65, 1'b1, 1'b1, 1'b1);
        do_resume("resume_at65", 8'd65, 1'b1, 1'b1);
        do_jump("jump2", 8'd2, 8'd2, 1'b0, 1'b1, 1'b1);
        do_jump("jump70", 8'd70, 8'd2, 1'b1, 1'b1, 1'b1);
        do_resume("resume_a", 8'd2, 1'b1, 1'b1);
        do_branch("br_wrap_fault", 1'b1, 8'hF0, 8'd2, 1'b1, 1'b1, 1'b1);
        do_resume("resume_b", 8'd2, 1'b1, 1'b1);
        do_call("call_oob", 8'd100, 8'd2, 1'b1, 1'b1, 1'b1);
        do_resume("resume_c", 8'd2, 1'b1, 1'b1);
        do_call("call10", 8'd10, 8'd10, 1'b0, 1'b1, 1'b1);
        do_ret("ret_to3", 8'd3, 1'b0, 1'b1, 1'b1);
        do_ret("ret_empty_again", 8'd3, 1'b1, 1'b1, 1'b1);
        do_resume("resume_at3", 8'd3, 1'b1, 1'b1);
        do_jump("jump65_legal", 8'd65, 8'd65, 1'b0, 1'b1, 1'b1);

        // Halt request overrides jump; halt holds with resume+halt_req
        do_jump("jump12", 8'd12, 8'd12, 1'b0, 1'b1, 1'b1);
        bus.halt_req = 1'b1;
        do_jump("halt_req", 8'd30, 8'd12, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) do_jump($sformatf("jump_in_halt_%0d", i), 8'd30, 8'd12, 1'b1, 1'b1, 1'b1);
        bus.halt_req = 1'b1; bus.resume = 1'b1;
        cyc("resume_and_halt", 8'd12, 1'b1, 1'b1, 1'b1);
        do_resume("resume_at12", 8'd12, 1'b1, 1'b1);
        cyc("inc_to_13", 8'd13, 1'b0, 1'b1, 1'b1);

        // Reset clears sticky flags
        reset = 1'b0;
        #1;
        chk("reset_clears_flags", 8'd0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clock);
        if (sb.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
